if_id_stage: RTL and testbench

- Pipeline stage between the fetch stage and decode. It consumes the instruction, PC and PC+4 produced by fetch_cycle.
- fetch_cycle's instruction ROM is synchronous: the instruction arrives one cycle after its PC. This block re-aligns PC metadata with the ROM data and registers the aligned triple for decode.
- It implements stall (hold) with a one-entry skid buffer, and flush (bubble insertion) for redirects.
- It drives fetch's pc_halt so that fetch and this stage always stall together.

---
 rtl/if_id_if.sv | 28 ++
 rtl/if_id_stage.sv | 91 +++++++++
 tb/tb_if_id_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_if.sv
// IF/ID boundary bundle: fetch-side inputs, hazard controls and the
// registered decode-side outputs of the IF/ID stage.
interface if_id_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] instr_in;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] pcPlus4_in;
  logic             stall;
  logic             flush;
  logic             pc_halt;
  logic [WIDTH-1:0] instr_id;
  logic [WIDTH-1:0] pc_id;
  logic [WIDTH-1:0] pcPlus4_id;
  logic             valid_id;

  // Fetch / hazard side drives the inputs and observes the ID outputs.
  modport master (
    output instr_in, pc_in, pcPlus4_in, stall, flush,
    input  pc_halt, instr_id, pc_id, pcPlus4_id, valid_id
  );

  // The stage itself.
  modport slave (
    input  instr_in, pc_in, pcPlus4_in, stall, flush,
    output pc_halt, instr_id, pc_id, pcPlus4_id, valid_id
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage. The fetch ROM is synchronous, so the PC metadata
// is delayed one cycle (meta) to line up with the ROM word. A one-entry
// skid keeps the ROM word alive across a stall, and flush turns the stage
// into a bubble while dropping the wrong-path word still in flight.
module if_id_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
  input logic    clk,
  input logic    rst,
  if_id_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc4;
    logic             valid;
  } id_t;

  logic [WIDTH-1:0] meta_pc, meta_pc4;
  logic             meta_valid;
  logic [WIDTH-1:0] skid_instr;
  logic             skid_valid;
  logic [WIDTH-1:0] sel_instr;
  logic             halt;
  id_t              id_q;

  // A redirect always wins over a hold so fetch can take the new target.
  assign halt        = bus.stall & ~bus.flush;
  assign bus.pc_halt = halt;

  // ROM word for the instruction described by meta.
  assign sel_instr = skid_valid ? skid_instr : bus.instr_in;

  // Alignment register: PC pair whose ROM word shows up next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_pc    <= '0;
      meta_pc4   <= '0;
      meta_valid <= 1'b0;
    end else if (!halt) begin
      meta_pc    <= bus.pc_in;
      meta_pc4   <= bus.pcPlus4_in;
      meta_valid <= ~bus.flush;
    end
  end

  // Skid: hold the first ROM word seen in a stall, since fetch re-reads
  // the next address and the ROM output is overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_instr <= NOP_INSTR;
    end else if (bus.flush) begin
      skid_valid <= 1'b0;
    end else if (bus.stall) begin
      if (!skid_valid) begin
        skid_instr <= bus.instr_in;
        skid_valid <= 1'b1;
      end
    end else begin
      skid_valid <= 1'b0;
    end
  end

  // ID register: flush > stall > advance. Bubbles carry NOP so decode
  // never sees a stale wrong-path word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q.instr <= NOP_INSTR;
      id_q.pc    <= '0;
      id_q.pc4   <= '0;
      id_q.valid <= 1'b0;
    end else if (bus.flush) begin
      id_q.instr <= NOP_INSTR;
      id_q.valid <= 1'b0;
    end else if (!bus.stall) begin
      id_q.instr <= meta_valid ? sel_instr : NOP_INSTR;
      id_q.pc    <= meta_pc;
      id_q.pc4   <= meta_pc4;
      id_q.valid <= meta_valid;
    end
  end

  assign bus.instr_id   = id_q.instr;
  assign bus.pc_id      = id_q.pc;
  assign bus.pcPlus4_id = id_q.pc4;
  assign bus.valid_id   = id_q.valid;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: a fetch + synchronous ROM model drives the stage;
// the expected ID contents come from a PC queue of issued-but-not-yet-at-ID
// fetches (flush empties it, stall freezes it).
module tb_if_id_stage;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_id_if #(.WIDTH(32)) bus ();
  if_id_stage #(.WIDTH(32), .NOP_INSTR(NOP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q[$];
  logic [31:0] fpc, rom_out, exp_pc;
  logic        exp_valid, exp_nop;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a + 32'h000000A0;
  endfunction

  // Hold reset for two edges, model back to power-on, release mid-cycle.
  task automatic do_reset();
    rst = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0;
    fpc = '0;
    bus.pc_in = '0; bus.pcPlus4_in = 32'd4; bus.instr_in = NOP;
    q.delete();
    exp_valid = 1'b0; exp_nop = 1'b1; exp_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One cycle: apply controls, check this cycle, then advance the models.
  task automatic step(input logic s, input logic f, input logic [31:0] tgt);
    bus.stall = s; bus.flush = f;
    #1;
    n_cmp++;
    if (bus.pc_halt !== (s & ~f)) begin
      n_err++; $display("FAIL pc_halt: got %b want %b", bus.pc_halt, s & ~f);
    end
    n_cmp++;
    if (bus.valid_id !== exp_valid) begin
      n_err++; $display("FAIL valid_id: got %b want %b", bus.valid_id, exp_valid);
    end
    if (exp_valid) begin
      n_cmp++;
      if (bus.pc_id !== exp_pc || bus.pcPlus4_id !== exp_pc + 32'd4 || bus.instr_id !== rom(exp_pc)) begin
        n_err++;
        $display("FAIL id_triple: got %h/%h/%h want %h/%h/%h", bus.pc_id, bus.pcPlus4_id,
                 bus.instr_id, exp_pc, exp_pc + 32'd4, rom(exp_pc));
      end
    end
    if (exp_nop) begin
      n_cmp++;
      if (bus.instr_id !== NOP) begin
        n_err++; $display("FAIL bubble_nop: got %h want %h", bus.instr_id, NOP);
      end
    end
    @(posedge clk);
    if (f) begin
      q.delete();
      exp_valid = 1'b0; exp_nop = 1'b1;
    end else if (!s) begin
      if (q.size() > 0) begin
        exp_pc = q.pop_front(); exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      exp_nop = 1'b0;
      q.push_back(fpc);
    end
    rom_out = rom(fpc);
    if (f) fpc = tgt;
    else if (!s) fpc = fpc + 32'd4;
    #1;
    bus.pc_in = fpc; bus.pcPlus4_in = fpc + 32'd4; bus.instr_in = rom_out;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.pc_in = '0; bus.pcPlus4_in = '0; bus.instr_in = NOP;
    #1;
    do_reset();
    n_cmp++;
    if (bus.instr_id !== NOP || bus.pc_id !== 0 || bus.pcPlus4_id !== 0 || bus.valid_id !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got %h/%h/%h/%b want %h/0/0/0", bus.instr_id, bus.pc_id,
               bus.pcPlus4_id, bus.valid_id, NOP);
    end
  endtask

  task automatic test_stream();
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0);
    n_cmp++;
    if (bus.pc_id !== 32'h8 || bus.instr_id !== 32'hA8 || bus.pcPlus4_id !== 32'hC || bus.valid_id !== 1'b1) begin
      n_err++;
      $display("FAIL stream_pc8: got %h/%h/%h/%b want 8/a8/c/1", bus.pc_id, bus.instr_id,
               bus.pcPlus4_id, bus.valid_id);
    end
  endtask

  task automatic test_stall_multi();
    // continues from ID holding 0x8
    repeat (3) step(1'b1, 1'b0, '0);
    n_cmp++;
    if (bus.pc_id !== 32'h8 || bus.instr_id !== 32'hA8) begin
      n_err++; $display("FAIL stall_hold: got %h/%h want 8/a8", bus.pc_id, bus.instr_id);
    end
    step(1'b0, 1'b0, '0);
    n_cmp++;
    if (bus.pc_id !== 32'hC || bus.instr_id !== 32'hAC || bus.valid_id !== 1'b1) begin
      n_err++; $display("FAIL stall_release_c: got %h/%h want c/ac", bus.pc_id, bus.instr_id);
    end
    step(1'b0, 1'b0, '0);
    n_cmp++;
    if (bus.pc_id !== 32'h10 || bus.instr_id !== 32'hB0) begin
      n_err++; $display("FAIL stall_release_10: got %h/%h want 10/b0", bus.pc_id, bus.instr_id);
    end
  endtask

  task automatic test_stall_one();
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    n_cmp++;
    if (bus.pc_id !== 32'hC || bus.instr_id !== 32'hAC) begin
      n_err++; $display("FAIL stall1_c: got %h/%h want c/ac", bus.pc_id, bus.instr_id);
    end
    step(1'b0, 1'b0, '0);
    n_cmp++;
    if (bus.pc_id !== 32'h10 || bus.instr_id !== 32'hB0) begin
      n_err++; $display("FAIL stall1_10: got %h/%h want 10/b0", bus.pc_id, bus.instr_id);
    end
  endtask

  // Shared body for flush with and without a simultaneous stall.
  task automatic test_flush(input logic with_stall, input logic [31:0] tgt);
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0);
    n_cmp++;
    if (bus.pc_in !== 32'h10) begin
      n_err++; $display("FAIL flush_setup: got %h want 10", bus.pc_in);
    end
    step(with_stall, 1'b1, tgt);
    n_cmp++;
    if (bus.valid_id !== 1'b0 || bus.instr_id !== NOP) begin
      n_err++; $display("FAIL flush_bubble1: got %b/%h want 0/%h", bus.valid_id, bus.instr_id, NOP);
    end
    step(1'b0, 1'b0, '0);
    n_cmp++;
    if (bus.valid_id !== 1'b0) begin
      n_err++; $display("FAIL flush_bubble2: got %b want 0", bus.valid_id);
    end
    step(1'b0, 1'b0, '0);
    n_cmp++;
    if (bus.pc_id !== tgt || bus.valid_id !== 1'b1 || bus.instr_id !== rom(tgt)) begin
      n_err++; $display("FAIL flush_target: got %h/%b want %h/1", bus.pc_id, bus.valid_id, tgt);
    end
    // a stall right after recovery shows any stale skid contents
    step(1'b1, 1'b0, '0);
    repeat (3) step(1'b0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h300);
    step(1'b0, 1'b1, 32'h400);
    step(1'b0, 1'b0, '0);
    n_cmp++;
    if (bus.valid_id !== 1'b0) begin
      n_err++; $display("FAIL b2b_bubble: got %b want 0", bus.valid_id);
    end
    step(1'b0, 1'b0, '0);
    n_cmp++;
    if (bus.pc_id !== 32'h400 || bus.valid_id !== 1'b1) begin
      n_err++; $display("FAIL b2b_target: got %h/%b want 400/1", bus.pc_id, bus.valid_id);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    bus.stall = 1'b1; bus.flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.valid_id !== 1'b0 || bus.instr_id !== NOP || bus.pc_id !== 0 || bus.pcPlus4_id !== 0) begin
      n_err++;
      $display("FAIL async_reset: got %b/%h/%h/%h want 0/%h/0/0", bus.valid_id, bus.instr_id,
               bus.pc_id, bus.pcPlus4_id, NOP);
    end
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0);
  endtask

  task automatic test_random();
    logic s, f;
    logic [31:0] tgt;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s   = ($urandom_range(0, 99) < 30);
      f   = ($urandom_range(0, 99) < 10);
      tgt = {16'h0, $urandom_range(0, 16383), 2'b00};
      step(s, f, tgt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_multi();
    test_stall_one();
    test_flush(1'b0, 32'h100);
    test_flush(1'b1, 32'h200);
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
